asrv32_memoryaccess: RTL and testbench
======================================

# asrv32_memoryaccess

Memory-access stage of the asrv32 core, directly upstream of the writeback stage. Once per instruction it issues a load or store to the data-memory bus, using a single-outstanding request/ack handshake. It holds the core's stage controller in stall until the access completes. For loads it aligns and sign- or zero-extends the returned word into `o_load_data`, which feeds writeback's load-data input.

## Interface
- `PC_RESET`, 32'h0: unused here; kept for uniform stage parameterisation.
- `TIMEOUT_CYCLES`, 255: maximum number of BUSY cycles spent waiting for ack before a bus error is raised. 0 disables the timeout.
- `i_clk` in 1: single clock; all state updates on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_memoryaccess_en` in 1: one-cycle pulse when the core enters the MEMORYACCESS stage.
- `i_opcode` in `OPCODE_WIDTH`: one-hot opcode; only `LOAD` and `STORE` access memory.
- `i_funct3` in 3: access size and sign. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `i_addr` in 32: effective address (ALU result).
- `i_rs2_data` in 32: store data.
- `o_load_data` out 32: extended load result, held until the next completed load.
- `o_done` out 1: one-cycle pulse when the stage finishes.
- `o_stall` out 1: combinational; high while an access is pending or in flight.
- `o_misaligned` out 1: one-cycle pulse, coincident with `o_done`.
- `o_bus_err` out 1: one-cycle pulse, coincident with `o_done`, on timeout.
- `o_wb_cyc`, `o_wb_stb` out 1: bus request; both registered and identical.
- `o_wb_we` out 1: 1 for store.
- `o_wb_addr` out 32: word address, {addr[31:2], 2'b00}.
- `o_wb_data` out 32: lane-replicated store data.
- `o_wb_sel` out 4: byte enables.
- `i_wb_ack` in 1: single-cycle completion from memory.
- `i_wb_data` in 32: read word, valid when `i_wb_ack` is high.

## Operation
- **States:** IDLE, BUSY, DONE.
- **Reset values:** state IDLE; all `o_wb_*` outputs 0; `o_load_data`, `o_done`, `o_misaligned`, `o_bus_err` all 0; timeout counter 0.
- **IDLE + en + (LOAD|STORE) + aligned:**
  - Latch address, sel, data and we.
  - Raise cyc/stb and go to BUSY.
- **IDLE + en + misaligned:** no bus cycle; go to DONE with `o_misaligned` set. Misaligned means:
  - H/HU with addr[0] = 1, or
  - W with addr[1:0] ≠ 0.
- **IDLE + en + any other opcode:** go to DONE; `o_load_data` is unchanged.
- **BUSY + ack:**
  - Drop cyc/stb.
  - For a load, capture the extended result into `o_load_data`.
  - Go to DONE.
- **BUSY + timeout:** when the counter reaches `TIMEOUT_CYCLES` (nonzero) without ack, drop cyc/stb, set `o_bus_err` and go to DONE.
- **DONE:** pulse `o_done` (with flags) for exactly one cycle, then return to IDLE.
- **Store lanes:**
  - SB: sel = 4'b0001 << addr[1:0], data = {4{rs2[7:0]}}.
  - SH: sel = 4'b0011 << {addr[1], 1'b0}, data = {2{rs2[15:0]}}.
  - SW: sel = 4'b1111, data = rs2.
- **Load lanes:**
  - B/BU: byte lane addr[1:0].
  - H/HU: half-word lane addr[1].
  - B/H are sign-extended; BU/HU are zero-extended.
  - Loads drive sel = 4'b1111.
- **Unsupported funct3 (011, 110, 111):** treated as W.
- **`o_stall`** = (state == BUSY) | (state == IDLE & en & (LOAD|STORE)).
- **Ignored inputs:** `i_wb_ack` is ignored outside BUSY. `i_memoryaccess_en` is ignored outside IDLE.
- **Reset mid-transaction:** cyc/stb drop asynchronously and state returns to IDLE. A late ack arriving after reset is ignored.

## Timing
- **Enable sampled at edge t:** cyc/stb are high during cycle t+1.
- **Ack high at edge t+k (k ≥ 1):**
  - cyc/stb are low from t+k.
  - `o_load_data` is valid from t+k.
  - `o_done` is high for cycle t+k+1 only.
- **Zero-wait memory (ack at t+1):** `o_done` is high at t+2, giving minimum latency 2 cycles from enable to done.
- **Non-memory or misaligned instruction:** `o_done` is high for cycle t+1 only; no bus activity.
- **Timeout:** cyc/stb are held for exactly `TIMEOUT_CYCLES` cycles. Error and done pulse the following cycle.
- **Bus stability:** bus address, sel, data and we stay stable for the entire time cyc is high.

## Test plan
- **LW, zero-wait:** LW addr 0x100, memory returns 0xDEADBEEF with ack one cycle after stb. Required: wb_addr = 0x100, sel = 1111, we = 0; `o_load_data` = 0xDEADBEEF; `o_done` 2 cycles after enable.
- **LB / LBU, lane 3:** LB, then LBU, at addr 0x203; memory word 0x80_11_22_33. Required: LB → 0xFFFFFF80, LBU → 0x00000080.
- **SH, upper half:** SH addr 0x102, rs2 = 0x0000ABCD. Required: wb_addr = 0x100, sel = 1100, data = 0xABCDABCD, we = 1.
- **Wait states:** SB addr 0x101 with ack delayed 5 cycles. Required: `o_stall` high for 6 cycles; cyc stable throughout; sel = 0010.
- **Misaligned and non-memory:** LW addr 0x102. Required: no cyc; `o_misaligned` and `o_done` high 1 cycle after enable. An ADD opcode gives done only, with no flags.
- **Timeout and reset:** with `TIMEOUT_CYCLES` = 4 and no ack, `o_bus_err` pulses after 4 BUSY cycles. Asserting `i_rst_n` = 0 mid-BUSY clears cyc immediately, and a subsequent ack is ignored.

Source files
------------

// File: rtl/asrv32_memoryaccess.sv
// asrv32 memory-access stage: issues one load/store per instruction on a
// single-outstanding cyc/stb/ack bus and returns the aligned, extended load result.
module asrv32_memoryaccess #(
  parameter logic [31:0] PC_RESET       = 32'h0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          OPCODE_WIDTH   = 11,
  parameter int          OPC_LOAD_IDX   = 2,
  parameter int          OPC_STORE_IDX  = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_memoryaccess_en,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_addr,
  input  logic [31:0]             i_rs2_data,
  output logic [31:0]             o_load_data,
  output logic                    o_done,
  output logic                    o_stall,
  output logic                    o_misaligned,
  output logic                    o_bus_err,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [31:0]             o_wb_addr,
  output logic [31:0]             o_wb_data,
  output logic [3:0]              o_wb_sel,
  input  logic                    i_wb_ack,
  input  logic [31:0]             i_wb_data
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wb_cyc_q;
  logic             wb_we_q;
  logic [31:0]      wb_addr_q;
  logic [31:0]      wb_data_q;
  logic [3:0]       wb_sel_q;
  logic             is_load_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic [31:0]      load_data_q;
  logic             done_q;
  logic             misaligned_q;
  logic             bus_err_q;

  logic             is_load;
  logic             is_store;
  logic             is_mem;
  logic             size_b;
  logic             size_h;
  logic             misaligned;
  logic [3:0]       req_sel;
  logic [31:0]      req_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      load_ext;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_hit;
  logic             unused_ok;

  assign unused_ok = ^{PC_RESET, i_opcode};

  assign is_load  = i_opcode[OPC_LOAD_IDX];
  assign is_store = i_opcode[OPC_STORE_IDX];
  assign is_mem   = is_load | is_store;

  // funct3[1:0] selects size; 011/110/111 fall through to word
  assign size_b = (i_funct3[1:0] == 2'b00);
  assign size_h = (i_funct3[1:0] == 2'b01);

  always_comb begin
    misaligned = 1'b0;
    if (size_h) begin
      misaligned = i_addr[0];
    end else if (!size_b) begin
      misaligned = |i_addr[1:0];
    end
  end

  always_comb begin
    req_sel  = 4'b1111;
    req_data = i_rs2_data;
    if (size_b) begin
      req_data = {4{i_rs2_data[7:0]}};
      if (is_store) begin
        req_sel = 4'b0001 << i_addr[1:0];
      end
    end else if (size_h) begin
      req_data = {2{i_rs2_data[15:0]}};
      if (is_store) begin
        req_sel = i_addr[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  // Extension uses the funct3/lane latched at request time, not live inputs
  always_comb begin
    ld_byte = 8'h00;
    case (addr_lo_q)
      2'd0:    ld_byte = i_wb_data[7:0];
      2'd1:    ld_byte = i_wb_data[15:8];
      2'd2:    ld_byte = i_wb_data[23:16];
      default: ld_byte = i_wb_data[31:24];
    endcase
    ld_half  = addr_lo_q[1] ? i_wb_data[31:16] : i_wb_data[15:0];
    load_ext = i_wb_data;
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: load_ext = i_wb_data;
    endcase
  end

  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_d == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wb_cyc_q     <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_addr_q    <= 32'h0;
      wb_data_q    <= 32'h0;
      wb_sel_q     <= 4'h0;
      is_load_q    <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      load_data_q  <= 32'h0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (i_memoryaccess_en) begin
            if (is_mem && !misaligned) begin
              wb_cyc_q  <= 1'b1;
              wb_we_q   <= is_store;
              wb_addr_q <= {i_addr[31:2], 2'b00};
              wb_data_q <= req_data;
              wb_sel_q  <= req_sel;
              is_load_q <= is_load;
              funct3_q  <= i_funct3;
              addr_lo_q <= i_addr[1:0];
              state_q   <= S_BUSY;
            end else begin
              done_q       <= 1'b1;
              misaligned_q <= is_mem;
              state_q      <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (i_wb_ack) begin
            wb_cyc_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
            if (is_load_q) begin
              load_data_q <= load_ext;
            end
          end else if (timeout_hit) begin
            wb_cyc_q  <= 1'b0;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_stall      = (state_q == S_BUSY) || ((state_q == S_IDLE) && i_memoryaccess_en && is_mem);
  assign o_load_data  = load_data_q;
  assign o_done       = done_q;
  assign o_misaligned = misaligned_q;
  assign o_bus_err    = bus_err_q;
  assign o_wb_cyc     = wb_cyc_q;
  assign o_wb_stb     = wb_cyc_q;
  assign o_wb_we      = wb_we_q;
  assign o_wb_addr    = wb_addr_q;
  assign o_wb_data    = wb_data_q;
  assign o_wb_sel     = wb_sel_q;

endmodule

// File: tb/tb_asrv32_memoryaccess.sv
// Directed, table-driven bench for asrv32_memoryaccess; a second instance with a
// short timeout covers the bus-error and mid-transaction reset cases.
module tb_asrv32_memoryaccess;

  localparam logic [10:0] OP_ADD   = 11'b000_0000_0001;
  localparam logic [10:0] OP_LOAD  = 11'b000_0000_0100;
  localparam logic [10:0] OP_STORE = 11'b000_0000_1000;

  typedef struct {
    logic [10:0] opc;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          k;      // BUSY cycles until ack; 0 = no bus cycle expected
    logic [31:0] waddr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        we;
    logic        mis;
    logic [31:0] load;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default timeout)
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [10:0] opc = '0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] rs2 = '0;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] load_data, wb_addr, wb_data;
  logic [3:0]  wb_sel;
  logic        done, stall, mis, bus_err, cyc, stb, we;

  // short-timeout instance
  logic        t_rst_n = 1'b0;
  logic        t_en = 1'b0;
  logic [10:0] t_opc = '0;
  logic [2:0]  t_f3 = '0;
  logic [31:0] t_addr = '0;
  logic        t_ack = 1'b0;
  logic [31:0] t_rdata = '0;
  logic [31:0] t_load_data, t_wb_addr, t_wb_data;
  logic [3:0]  t_wb_sel;
  logic        t_done, t_stall, t_mis, t_bus_err, t_cyc, t_stb, t_we;

  asrv32_memoryaccess #(.TIMEOUT_CYCLES(255)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_memoryaccess_en(en), .i_opcode(opc),
    .i_funct3(f3), .i_addr(addr), .i_rs2_data(rs2), .o_load_data(load_data),
    .o_done(done), .o_stall(stall), .o_misaligned(mis), .o_bus_err(bus_err),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_data), .o_wb_sel(wb_sel), .i_wb_ack(ack), .i_wb_data(rdata)
  );

  asrv32_memoryaccess #(.TIMEOUT_CYCLES(4)) dut_to (
    .i_clk(clk), .i_rst_n(t_rst_n), .i_memoryaccess_en(t_en), .i_opcode(t_opc),
    .i_funct3(t_f3), .i_addr(t_addr), .i_rs2_data(32'h0), .o_load_data(t_load_data),
    .o_done(t_done), .o_stall(t_stall), .o_misaligned(t_mis), .o_bus_err(t_bus_err),
    .o_wb_cyc(t_cyc), .o_wb_stb(t_stb), .o_wb_we(t_we), .o_wb_addr(t_wb_addr),
    .o_wb_data(t_wb_data), .o_wb_sel(t_wb_sel), .i_wb_ack(t_ack), .i_wb_data(t_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic exp_stall;
    int   stall_cnt;
    exp_stall = |(v.opc & (OP_LOAD | OP_STORE));
    en = 1'b1; opc = v.opc; f3 = v.f3; addr = v.addr; rs2 = v.rs2;
    #1;
    chk($sformatf("v%0d stall_at_en", idx), {31'h0, stall}, {31'h0, exp_stall});
    stall_cnt = stall ? 1 : 0;
    @(posedge clk); @(negedge clk);
    // scramble live inputs: bus fields and load extension must come from latched state
    en = 1'b0; opc = '0; f3 = 3'b111; addr = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
    #1;
    for (int i = 1; i <= v.k; i++) begin
      chk($sformatf("v%0d cyc c%0d", idx, i), {31'h0, cyc}, 32'h1);
      chk($sformatf("v%0d stb c%0d", idx, i), {31'h0, stb}, 32'h1);
      chk($sformatf("v%0d addr c%0d", idx, i), wb_addr, v.waddr);
      chk($sformatf("v%0d sel c%0d", idx, i), {28'h0, wb_sel}, {28'h0, v.sel});
      chk($sformatf("v%0d we c%0d", idx, i), {31'h0, we}, {31'h0, v.we});
      if (v.we) chk($sformatf("v%0d wdata c%0d", idx, i), wb_data, v.wdata);
      chk($sformatf("v%0d early_done c%0d", idx, i), {31'h0, done}, 32'h0);
      if (stall) stall_cnt++;
      if (i == v.k) begin
        ack = 1'b1; rdata = v.rdata;
      end
      @(posedge clk); @(negedge clk);
      ack = 1'b0; rdata = 32'h0BAD_F00D;
      #1;
    end
    chk($sformatf("v%0d cyc_after", idx), {31'h0, cyc}, 32'h0);
    chk($sformatf("v%0d done", idx), {31'h0, done}, 32'h1);
    chk($sformatf("v%0d misaligned", idx), {31'h0, mis}, {31'h0, v.mis});
    chk($sformatf("v%0d bus_err", idx), {31'h0, bus_err}, 32'h0);
    chk($sformatf("v%0d load_data", idx), load_data, v.load);
    chk($sformatf("v%0d stall_cycles", idx), stall_cnt, exp_stall ? 1 + v.k : 0);
    @(negedge clk); #1;
    chk($sformatf("v%0d done_pulse_end", idx), {31'h0, done}, 32'h0);
    chk($sformatf("v%0d mis_pulse_end", idx), {31'h0, mis}, 32'h0);
    $display("vec %0d opc=%h f3=%b addr=%h k=%0d load=%h stall_cycles=%0d",
             idx, v.opc, v.f3, v.addr, v.k, load_data, stall_cnt);
  endtask

  vec_t vecs[14];

  initial begin
    //          opc       f3      addr          rs2           rdata         k  waddr         sel      wdata         we    mis   load
    vecs[0]  = '{OP_LOAD,  3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{OP_LOAD,  3'b000, 32'h0000_0203, 32'h0,        32'h8011_2233, 1, 32'h0000_0200, 4'b1111, 32'h0,        1'b0, 1'b0, 32'hFFFF_FF80};
    vecs[2]  = '{OP_LOAD,  3'b100, 32'h0000_0203, 32'h0,        32'h8011_2233, 1, 32'h0000_0200, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h0000_0080};
    vecs[3]  = '{OP_STORE, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0,        1, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 1'b1, 1'b0, 32'h0000_0080};
    vecs[4]  = '{OP_STORE, 3'b000, 32'h0000_0101, 32'h0000_005A, 32'h0,        5, 32'h0000_0100, 4'b0010, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0000_0080};
    vecs[5]  = '{OP_LOAD,  3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 32'h0000_0080};
    vecs[6]  = '{OP_ADD,   3'b010, 32'h0000_0103, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b0, 32'h0000_0080};
    vecs[7]  = '{OP_LOAD,  3'b001, 32'h0000_0206, 32'h0,        32'h8001_7FFF, 1, 32'h0000_0204, 4'b1111, 32'h0,        1'b0, 1'b0, 32'hFFFF_8001};
    vecs[8]  = '{OP_LOAD,  3'b101, 32'h0000_0206, 32'h0,        32'h8001_7FFF, 1, 32'h0000_0204, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h0000_8001};
    vecs[9]  = '{OP_STORE, 3'b010, 32'h0000_010C, 32'h1234_5678, 32'h0,        2, 32'h0000_010C, 4'b1111, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_8001};
    vecs[10] = '{OP_LOAD,  3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1, 32'h0000_8001};
    vecs[11] = '{OP_LOAD,  3'b011, 32'h0000_0104, 32'h0,        32'hCAFE_F00D, 3, 32'h0000_0104, 4'b1111, 32'h0,        1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[12] = '{OP_LOAD,  3'b000, 32'h0000_0201, 32'h0,        32'h0000_7F00, 1, 32'h0000_0200, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h0000_007F};
    vecs[13] = '{OP_LOAD,  3'b001, 32'h0000_0200, 32'h0,        32'h1234_F00F, 1, 32'h0000_0200, 4'b1111, 32'h0,        1'b0, 1'b0, 32'hFFFF_F00F};

    // reset state
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; t_rst_n = 1'b1;
    #1;
    chk("rst cyc", {31'h0, cyc}, 32'h0);
    chk("rst stb", {31'h0, stb}, 32'h0);
    chk("rst we", {31'h0, we}, 32'h0);
    chk("rst addr", wb_addr, 32'h0);
    chk("rst data", wb_data, 32'h0);
    chk("rst sel", {28'h0, wb_sel}, 32'h0);
    chk("rst load_data", load_data, 32'h0);
    chk("rst done", {31'h0, done}, 32'h0);
    chk("rst mis", {31'h0, mis}, 32'h0);
    chk("rst bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst stall", {31'h0, stall}, 32'h0);

    @(negedge clk);
    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // stray ack while idle must not complete anything
    ack = 1'b1; rdata = 32'h5555_5555;
    @(posedge clk); @(negedge clk);
    ack = 1'b0;
    #1;
    chk("idle_ack done", {31'h0, done}, 32'h0);
    chk("idle_ack load_data", load_data, 32'hFFFF_F00F);
    $display("idle ack ignored load=%h", load_data);

    // timeout: 4 BUSY cycles without ack
    @(negedge clk);
    t_en = 1'b1; t_opc = OP_LOAD; t_f3 = 3'b010; t_addr = 32'h0000_0300;
    @(posedge clk); @(negedge clk);
    t_en = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to cyc c%0d", i), {31'h0, t_cyc}, 32'h1);
      chk($sformatf("to bus_err c%0d", i), {31'h0, t_bus_err}, 32'h0);
      @(posedge clk); @(negedge clk); #1;
    end
    chk("to cyc_after", {31'h0, t_cyc}, 32'h0);
    chk("to bus_err", {31'h0, t_bus_err}, 32'h1);
    chk("to done", {31'h0, t_done}, 32'h1);
    chk("to load_data", t_load_data, 32'h0);
    @(negedge clk); #1;
    chk("to bus_err_end", {31'h0, t_bus_err}, 32'h0);
    chk("to done_end", {31'h0, t_done}, 32'h0);
    $display("timeout addr=%h bus_err pulse observed", t_wb_addr);

    // reset mid-BUSY, then a late ack
    @(negedge clk);
    t_en = 1'b1; t_opc = OP_LOAD; t_f3 = 3'b010; t_addr = 32'h0000_0400;
    @(posedge clk); @(negedge clk);
    t_en = 1'b0;
    #1;
    chk("rstmid cyc_before", {31'h0, t_cyc}, 32'h1);
    @(posedge clk); @(negedge clk);
    t_rst_n = 1'b0;
    #1;
    chk("rstmid cyc", {31'h0, t_cyc}, 32'h0);
    chk("rstmid stb", {31'h0, t_stb}, 32'h0);
    @(negedge clk);
    t_rst_n = 1'b1; t_ack = 1'b1; t_rdata = 32'h1111_1111;
    @(posedge clk); @(negedge clk);
    t_ack = 1'b0;
    #1;
    chk("late_ack done", {31'h0, t_done}, 32'h0);
    chk("late_ack load_data", t_load_data, 32'h0);
    chk("late_ack cyc", {31'h0, t_cyc}, 32'h0);
    $display("reset mid-busy cyc=%b late ack load=%h", t_cyc, t_load_data);

    // the instance recovers: LBU lane 1
    t_en = 1'b1; t_opc = OP_LOAD; t_f3 = 3'b100; t_addr = 32'h0000_0401;
    @(posedge clk); @(negedge clk);
    t_en = 1'b0; t_ack = 1'b1; t_rdata = 32'h0000_AA00;
    #1;
    chk("recover cyc", {31'h0, t_cyc}, 32'h1);
    chk("recover addr", t_wb_addr, 32'h0000_0400);
    @(posedge clk); @(negedge clk);
    t_ack = 1'b0;
    #1;
    chk("recover done", {31'h0, t_done}, 32'h1);
    chk("recover load_data", t_load_data, 32'h0000_00AA);
    $display("recovery LBU load=%h", t_load_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
